e_mdu: RTL and testbench
========================

Name: e_mdu

Overview:
- Execute-stage multiply/divide unit for the 5-stage MIPS pipeline.
- Sits beside e_alu, downstream of de_reg, and consumes the forwarded rs/rt operands (e_fwd_grf_rs / e_fwd_grf_rt).
- Holds architectural HI/LO and models multi-cycle MULT/MULTU/DIV/DIVU latency with a busy counter.
- Drives busy/start to the stall unit and supplies MFHI/MFLO data into the E-stage write-back select.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (legal range 1..15).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (legal range 1..15).

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- issue_en  in  1  E-stage slot holds a real instruction, not a bubble; mduOp is ignored when low.
- mduOp  in  4  operation code (package constants): NOPE, MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO.
- srcA  in  32  forwarded rs value.
- srcB  in  32  forwarded rt value.
- start  out  1  combinational: issue_en & mduOp ∈ {MULT, MULTU, DIV, DIVU}.
- busy  out  1  registered: an operation is in flight.
- hi  out  32  architectural HI.
- lo  out  32  architectural LO.
- mduRd  out  32  combinational: hi if mduOp==MFHI, lo if mduOp==MFLO, else 0.

Behaviour:
- Reset (reset==0 at a clk edge):
  - busy=0, hi=0, lo=0, counter=0.
  - Pending HI/LO staging registers are cleared and any in-flight result is discarded.
  - Reset has priority over every other event.
- States:
  - IDLE: busy=0.
  - RUN: busy=1, counter counts down.
- IDLE→RUN, on an edge where start==1:
  - Latch op kind.
  - Compute the result from srcA/srcB on that edge and store it in staging registers.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
  - busy becomes 1 in the following cycle.
- RUN: decrement counter every edge. On the edge where counter==1:
  - Commit staging to hi/lo.
  - busy becomes 0.
  - Net effect: busy is high for exactly N cycles; new hi/lo are visible in the first cycle busy is low.
- Arithmetic:
  - MULT: {hi,lo} = signed 64-bit srcA*srcB.
  - MULTU: {hi,lo} = unsigned 64-bit srcA*srcB.
  - DIV: lo = signed quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
- Divide by zero (srcB==0):
  - The unit still goes busy for DIV_CYCLES.
  - hi/lo stay unchanged at commit.
- DIV of 0x80000000 by 0xFFFFFFFF: lo=0x80000000, hi=0.
- MTHI/MTLO:
  - When issue_en and not busy, write srcA into hi (MTHI) or lo (MTLO) on that edge.
  - No busy cycles.
- Any op arriving while busy (start, MT*, MF*) is ignored by the unit.
  - The stall unit holds D while (start|busy) and D needs the MDU, so this occurs only on bench misuse.
  - mduRd still reflects current hi/lo.
- MF* reads are combinational from the current hi/lo. The same-edge MT write is not bypassed, because MT and MF cannot share the E stage in one cycle.
- issue_en==0: start=0 and mduRd=0, whatever mduOp holds.

Optional Feature:
- Macro: MDU_MADD_EN.
- When defined:
  - Adds ops MADD, MADDU, MSUB, MSUBU.
  - {hi,lo} ± (srcA*srcB), signed or unsigned; the 64-bit accumulate wraps modulo 2^64.
  - The accumulator base is hi/lo as sampled on the issue edge.
  - Uses MULT_CYCLES latency and asserts start.
- When undefined:
  - These opcodes decode as NOPE (start=0, no state change).
  - The multiply-accumulate datapath is absent.

Decomposition:
- def.v holds:
  - mduOp_* constants (4-bit).
  - mduOp_madd… constants, present regardless of the macro.
  - regWdSel_mdu added to the existing regWdSel set.
- No sub-module. The counter, FSM and staging registers are small enough to stay flat in e_mdu.
- controller gains an mduOp output decoded from funct.

Test Plan:
- Reset held low for 2 cycles mid-RUN of a DIV → busy=0, hi=lo=0 on the next cycle; no late commit afterwards.
- MULT srcA=0xFFFFFFFE (-2), srcB=3 → busy high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same inputs → hi=0x00000002, lo=0xFFFFFFFA.
- DIV srcA=-7 (0xFFFFFFF9), srcB=2 → busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/0 → busy 10 cycles, hi/lo unchanged.
- MTHI 0x12345678, then MFHI next cycle → mduRd=0x12345678, busy stays 0. MTLO while busy → lo unchanged after commit.
- start pulsed during busy with a different op → ignored: original result commits, busy length is unchanged, and busy drops at the original cycle.
- With MDU_MADD_EN: hi=0, lo=0xFFFFFFFF, MADDU 1*1 → hi=1, lo=0 after 5 cycles. Without MDU_MADD_EN, the same opcode → start=0 and hi/lo unchanged.

Source files
------------

// File: rtl/e_mdu_pkg.sv
// e_mdu_pkg: shared definitions for the execute-stage multiply/divide unit.
//   - 4-bit mduOp encodings (MADD family encodings always defined)
//   - regWdSel code that selects MDU read data in the E-stage write-back mux
//   - FSM state type and opcode classification helpers
// Optional build macro: MDU_MADD_EN (enables the MADD/MADDU/MSUB/MSUBU ops).
package e_mdu_pkg;

  localparam int MDU_OP_W = 4;

  localparam logic [MDU_OP_W-1:0] MDUOP_NOPE  = 4'd0;
  localparam logic [MDU_OP_W-1:0] MDUOP_MULT  = 4'd1;
  localparam logic [MDU_OP_W-1:0] MDUOP_MULTU = 4'd2;
  localparam logic [MDU_OP_W-1:0] MDUOP_DIV   = 4'd3;
  localparam logic [MDU_OP_W-1:0] MDUOP_DIVU  = 4'd4;
  localparam logic [MDU_OP_W-1:0] MDUOP_MFHI  = 4'd5;
  localparam logic [MDU_OP_W-1:0] MDUOP_MFLO  = 4'd6;
  localparam logic [MDU_OP_W-1:0] MDUOP_MTHI  = 4'd7;
  localparam logic [MDU_OP_W-1:0] MDUOP_MTLO  = 4'd8;
  localparam logic [MDU_OP_W-1:0] MDUOP_MADD  = 4'd9;
  localparam logic [MDU_OP_W-1:0] MDUOP_MADDU = 4'd10;
  localparam logic [MDU_OP_W-1:0] MDUOP_MSUB  = 4'd11;
  localparam logic [MDU_OP_W-1:0] MDUOP_MSUBU = 4'd12;

  // Write-back select code for MFHI/MFLO results in the E-stage mux.
  localparam logic [2:0] REGWDSEL_MDU = 3'd4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_t;

  // Multiply-accumulate opcodes are only recognised when the datapath exists;
  // otherwise they fall through as NOPE.
  function automatic logic is_mac_op(input logic [MDU_OP_W-1:0] op);
`ifdef MDU_MADD_EN
    return (op == MDUOP_MADD) || (op == MDUOP_MADDU) ||
           (op == MDUOP_MSUB) || (op == MDUOP_MSUBU);
`else
    return (op == 4'hF) && 1'b0;
`endif
  endfunction

  function automatic logic is_mul_op(input logic [MDU_OP_W-1:0] op);
    return (op == MDUOP_MULT) || (op == MDUOP_MULTU) || is_mac_op(op);
  endfunction

  function automatic logic is_div_op(input logic [MDU_OP_W-1:0] op);
    return (op == MDUOP_DIV) || (op == MDUOP_DIVU);
  endfunction

endpackage

// File: rtl/e_mdu_if.sv
// e_mdu_if: E-stage <-> MDU signal bundle.
//   issue_en, mduOp, srcA, srcB : pipeline -> MDU
//   start, busy                 : MDU -> stall unit
//   hi, lo                      : architectural HI/LO
//   mduRd                       : MFHI/MFLO read data for write-back select
// master = pipeline side, slave = e_mdu.
// Optional build macro affecting the opcode set: MDU_MADD_EN.
interface e_mdu_if;
  import e_mdu_pkg::*;

  logic                issue_en;
  logic [MDU_OP_W-1:0] mduOp;
  logic [31:0]         srcA;
  logic [31:0]         srcB;
  logic                start;
  logic                busy;
  logic [31:0]         hi;
  logic [31:0]         lo;
  logic [31:0]         mduRd;

  modport master (
    output issue_en, mduOp, srcA, srcB,
    input  start, busy, hi, lo, mduRd
  );

  modport slave (
    input  issue_en, mduOp, srcA, srcB,
    output start, busy, hi, lo, mduRd
  );

endinterface

// File: rtl/e_mdu.sv
// e_mdu: execute-stage multiply/divide unit.
// Ports:
//   clk   - pipeline clock
//   reset - synchronous active-low reset
//   bus   - e_mdu_if.slave (issue_en, mduOp, srcA, srcB in;
//           start, busy, hi, lo, mduRd out)
// The result is computed on the issue edge and parked in staging registers;
// a down-counter models the multi-cycle latency and commits to HI/LO when it
// reaches its terminal count.
// Optional build macro: MDU_MADD_EN (MADD/MADDU/MSUB/MSUBU, MULT latency).
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no op in flight, busy=0, MT*/new starts accepted
// ST_RUN  | op in flight, busy=1, counter decrements, commit at cnt==1
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,   // legal 1..15
  parameter int DIV_CYCLES  = 10   // legal 1..15
) (
  input logic   clk,
  input logic   reset,
  e_mdu_if.slave bus
);

  mdu_state_t  state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic        load, commit;

  logic [31:0] hi_q, lo_q;
  logic [31:0] stg_hi, stg_lo;
  logic        stg_we;

  logic [31:0] res_hi, res_lo;
  logic        res_we;

  logic        accept_mt_hi, accept_mt_lo;

  // ---------------------------------------------------------------------------
  // Handshake / read path
  // ---------------------------------------------------------------------------
  assign bus.start = bus.issue_en & (is_mul_op(bus.mduOp) | is_div_op(bus.mduOp));
  assign bus.busy  = (state == ST_RUN);
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;

  always_comb begin
    bus.mduRd = 32'd0;
    if (bus.issue_en) begin
      if (bus.mduOp == MDUOP_MFHI)      bus.mduRd = hi_q;
      else if (bus.mduOp == MDUOP_MFLO) bus.mduRd = lo_q;
    end
  end

  assign accept_mt_hi = bus.issue_en && (state == ST_IDLE) && (bus.mduOp == MDUOP_MTHI);
  assign accept_mt_lo = bus.issue_en && (state == ST_IDLE) && (bus.mduOp == MDUOP_MTLO);

  // ---------------------------------------------------------------------------
  // Arithmetic (evaluated from srcA/srcB, captured on the issue edge)
  // ---------------------------------------------------------------------------
  logic [63:0] prod_s, prod_u;
  logic        div_signed, a_neg, b_neg;
  logic [31:0] abs_a, abs_b, dvd, dvs, dvs_safe, q_u, r_u, quo, rem;

  // Extending to 64 bits first makes the low 64 bits of an unsigned multiply
  // equal to the two's-complement signed product.
  assign prod_s = {{32{bus.srcA[31]}}, bus.srcA} * {{32{bus.srcB[31]}}, bus.srcB};
  assign prod_u = {32'd0, bus.srcA} * {32'd0, bus.srcB};

  // Signed divide is done on magnitudes so 0x80000000 / -1 wraps to
  // 0x80000000 with remainder 0 instead of relying on overflow behaviour.
  assign div_signed = (bus.mduOp == MDUOP_DIV);
  assign a_neg      = div_signed & bus.srcA[31];
  assign b_neg      = div_signed & bus.srcB[31];
  assign abs_a      = a_neg ? (~bus.srcA + 32'd1) : bus.srcA;
  assign abs_b      = b_neg ? (~bus.srcB + 32'd1) : bus.srcB;
  assign dvd        = abs_a;
  assign dvs        = abs_b;
  assign dvs_safe   = (dvs == 32'd0) ? 32'd1 : dvs;
  assign q_u        = dvd / dvs_safe;
  assign r_u        = dvd % dvs_safe;
  assign quo        = (a_neg ^ b_neg) ? (~q_u + 32'd1) : q_u;
  assign rem        = a_neg ? (~r_u + 32'd1) : r_u;

  always_comb begin
    res_hi = hi_q;
    res_lo = lo_q;
    res_we = 1'b0;
    case (bus.mduOp)
      MDUOP_MULT: begin
        {res_hi, res_lo} = prod_s;
        res_we           = 1'b1;
      end
      MDUOP_MULTU: begin
        {res_hi, res_lo} = prod_u;
        res_we           = 1'b1;
      end
      MDUOP_DIV, MDUOP_DIVU: begin
        res_hi = rem;
        res_lo = quo;
        // Divide by zero still occupies the unit but leaves HI/LO alone.
        res_we = (bus.srcB != 32'd0);
      end
`ifdef MDU_MADD_EN
      MDUOP_MADD: begin
        {res_hi, res_lo} = {hi_q, lo_q} + prod_s;
        res_we           = 1'b1;
      end
      MDUOP_MADDU: begin
        {res_hi, res_lo} = {hi_q, lo_q} + prod_u;
        res_we           = 1'b1;
      end
      MDUOP_MSUB: begin
        {res_hi, res_lo} = {hi_q, lo_q} - prod_s;
        res_we           = 1'b1;
      end
      MDUOP_MSUBU: begin
        {res_hi, res_lo} = {hi_q, lo_q} - prod_u;
        res_we           = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: next state / counter
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    load     = 1'b0;
    commit   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          state_nx = ST_RUN;
          load     = 1'b1;
          cnt_nx   = is_div_op(bus.mduOp) ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
        end
      end
      ST_RUN: begin
        cnt_nx = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_nx = ST_IDLE;
          commit   = 1'b1;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = 4'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, staging and architectural registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= ST_IDLE;
      cnt    <= 4'd0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
      stg_hi <= 32'd0;
      stg_lo <= 32'd0;
      stg_we <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (load) begin
        stg_hi <= res_hi;
        stg_lo <= res_lo;
        stg_we <= res_we;
      end
      // Commit only happens in RUN and MT* only in IDLE, so they never collide.
      if (commit && stg_we) begin
        hi_q <= stg_hi;
        lo_q <= stg_lo;
      end
      if (accept_mt_hi) hi_q <= bus.srcA;
      if (accept_mt_lo) lo_q <= bus.srcA;
    end
  end

endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: scoreboard bench for e_mdu.
// Expected HI/LO/busy-length are queued at issue and compared when busy drops.
// Honors MDU_MADD_EN to pick the expected behaviour of the MADDU opcode.
module tb_e_mdu;
  import e_mdu_pkg::*;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
  } exp_t;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;
  exp_t sb_q[$];

  e_mdu_if mif ();

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (mif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    mif.issue_en = 1'b0;
    mif.mduOp    = MDUOP_NOPE;
    mif.srcA     = 32'd0;
    mif.srcB     = 32'd0;
  endtask

  task automatic mt_op(input logic [3:0] op, input logic [31:0] val);
    @(negedge clk);
    mif.issue_en = 1'b1;
    mif.mduOp    = op;
    mif.srcA     = val;
    @(negedge clk);
    idle_inputs();
  endtask

  // Issue a long op, optionally poke other ops while busy, then wait for
  // busy to drop and check against the scoreboard entry.
  task automatic run_op(input string tag, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input int exp_len, input bit inject);
    exp_t e;
    int   len;
    @(negedge clk);
    mif.issue_en = 1'b1;
    mif.mduOp    = op;
    mif.srcA     = a;
    mif.srcB     = b;
    e.hi = exp_hi; e.lo = exp_lo; e.len = exp_len;
    sb_q.push_back(e);
    #1;
    chk({tag, "_start"}, {63'd0, mif.start}, 64'd1);
    @(negedge clk);
    idle_inputs();
    len = 0;
    while (mif.busy && len < 40) begin
      len++;
      if (inject && len == 2) begin
        mif.issue_en = 1'b1; mif.mduOp = MDUOP_DIV; mif.srcA = 32'd1; mif.srcB = 32'd1;
      end else if (inject && len == 3) begin
        mif.issue_en = 1'b1; mif.mduOp = MDUOP_MTLO; mif.srcA = 32'hDEAD_BEEF;
      end else begin
        idle_inputs();
      end
      @(negedge clk);
    end
    idle_inputs();
    e = sb_q.pop_front();
    chk({tag, "_len"}, 64'(len), 64'(e.len));
    chk({tag, "_hi"}, {32'd0, mif.hi}, {32'd0, e.hi});
    chk({tag, "_lo"}, {32'd0, mif.lo}, {32'd0, e.lo});
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    idle_inputs();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    chk("rst_busy", {63'd0, mif.busy}, 64'd0);
    chk("rst_hi", {32'd0, mif.hi}, 64'd0);
    chk("rst_lo", {32'd0, mif.lo}, 64'd0);

    // MTHI / MFHI, MTLO / MFLO
    mt_op(MDUOP_MTHI, 32'h1234_5678);
    mif.issue_en = 1'b1; mif.mduOp = MDUOP_MFHI;
    #1;
    chk("mfhi_rd", {32'd0, mif.mduRd}, 64'h1234_5678);
    chk("mt_busy", {63'd0, mif.busy}, 64'd0);
    idle_inputs();
    mt_op(MDUOP_MTLO, 32'hCAFE_F00D);
    mif.issue_en = 1'b1; mif.mduOp = MDUOP_MFLO;
    #1;
    chk("mflo_rd", {32'd0, mif.mduRd}, 64'hCAFE_F00D);
    // Bubble: no start, no read data regardless of opcode
    mif.issue_en = 1'b0;
    #1;
    chk("bubble_rd", {32'd0, mif.mduRd}, 64'd0);
    mif.mduOp = MDUOP_MULT;
    #1;
    chk("bubble_start", {63'd0, mif.start}, 64'd0);
    idle_inputs();

    run_op("mult",  MDUOP_MULT,  32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5, 1'b0);
    run_op("multu", MDUOP_MULTU, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, 5, 1'b0);
    run_op("div",   MDUOP_DIV,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, 1'b0);
    run_op("divu0", MDUOP_DIVU,  32'd7, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, 1'b0);
    run_op("divov", MDUOP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 10, 1'b0);
    run_op("divu",  MDUOP_DIVU,  32'd100, 32'd7, 32'd2, 32'd14, 10, 1'b0);
    run_op("divrm", MDUOP_DIV,   32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 10, 1'b0);
    // Ops during busy (DIV and MTLO) must be ignored
    run_op("inject", MDUOP_MULT, 32'd3, 32'd4, 32'd0, 32'd12, 5, 1'b1);

    // Multiply-accumulate opcode
    mt_op(MDUOP_MTHI, 32'd0);
    mt_op(MDUOP_MTLO, 32'hFFFF_FFFF);
`ifdef MDU_MADD_EN
    run_op("maddu", MDUOP_MADDU, 32'd1, 32'd1, 32'd1, 32'd0, 5, 1'b0);
`else
    @(negedge clk);
    mif.issue_en = 1'b1; mif.mduOp = MDUOP_MADDU; mif.srcA = 32'd1; mif.srcB = 32'd1;
    #1;
    chk("maddu_start", {63'd0, mif.start}, 64'd0);
    @(negedge clk);
    idle_inputs();
    repeat (6) @(negedge clk);
    chk("maddu_busy", {63'd0, mif.busy}, 64'd0);
    chk("maddu_hilo", {mif.hi, mif.lo}, 64'h0000_0000_FFFF_FFFF);
`endif

    // Reset mid-RUN of a DIV: no late commit
    mt_op(MDUOP_MTHI, 32'h5555_AAAA);
    @(negedge clk);
    mif.issue_en = 1'b1; mif.mduOp = MDUOP_DIVU; mif.srcA = 32'd100; mif.srcB = 32'd7;
    @(negedge clk);
    idle_inputs();
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", {63'd0, mif.busy}, 64'd1);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    chk("midrst_busy", {63'd0, mif.busy}, 64'd0);
    chk("midrst_hilo", {mif.hi, mif.lo}, 64'd0);
    repeat (15) @(negedge clk);
    chk("late_busy", {63'd0, mif.busy}, 64'd0);
    chk("late_hilo", {mif.hi, mif.lo}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
